spi_baud_gen: RTL and testbench

SPI_BAUD_GEN -- requirements
Module: spi_baud_gen

---
 rtl/spi_baud_gen_pkg.sv | 12 +
 rtl/spi_baud_gen_if.sv | 27 ++
 rtl/spi_baud_gen.sv | 63 ++++++
 tb/tb_spi_baud_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spi_baud_gen_pkg.sv
// Shared SPI definitions: spi_mode encodings and the default divisor width.
package spi_pkg;

  localparam int DIV_W = 12;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_WAIT = 2'b01,
    MODE_STOP = 2'b10   // 2'b11 is reserved and also behaves as stop
  } spi_mode_e;

endpackage

// File: rtl/spi_baud_gen_if.sv
// Control/strobe bundle between the SPI controller (master side) and the
// baud generator (slave side).
interface spi_baud_gen_if #(parameter int DIV_W = spi_pkg::DIV_W);
  logic [1:0]       spi_mode;
  logic             spiswai;
  logic [2:0]       sppr;
  logic [2:0]       spr;
  logic             cpol;
  logic             cpha;
  logic             ss;
  logic             sclk;
  logic             flag_low;
  logic             flag_high;
  logic             flags_low;
  logic             flags_high;
  logic [DIV_W-1:0] baud_rate_divisor;

  modport master (
    output spi_mode, spiswai, sppr, spr, cpol, cpha, ss,
    input  sclk, flag_low, flag_high, flags_low, flags_high, baud_rate_divisor
  );

  modport slave (
    input  spi_mode, spiswai, sppr, spr, cpol, cpha, ss,
    output sclk, flag_low, flag_high, flags_low, flags_high, baud_rate_divisor
  );
endinterface

// File: rtl/spi_baud_gen.sv
// SPI baud-rate generator: divides PCLK by (sppr+1)*2^(spr+1) to form sclk
// and emits one-cycle sample (flag_*) and shift (flags_*) strobes for both
// sclk levels. The consumer picks the level matching cpol^cpha.
module spi_baud_gen #(parameter int DIV_W = spi_pkg::DIV_W) (
  input  logic          PCLK,
  input  logic          PRESET,
  spi_baud_gen_if.slave bus
);
  import spi_pkg::*;

  logic [DIV_W-1:0] divisor, hp, hp_m1, tx_pt;
  logic [DIV_W-1:0] count, cnt_nxt;
  logic             sclk_q, sclk_nxt;
  logic             active, wrap;
  logic             flag_low_q, flag_high_q, flags_low_q, flags_high_q;

  // Phase selection belongs to the shift register; this block is phase-agnostic.
  logic unused_cpha;
  assign unused_cpha = bus.cpha;

  // Divisor, half period and strobe points; next-state of counter and sclk.
  always_comb begin
    divisor  = (DIV_W'(bus.sppr) + DIV_W'(1)) << (4'(bus.spr) + 4'd1);
    hp       = divisor >> 1;
    hp_m1    = hp - DIV_W'(1);
    // With a one-cycle half period the shift point folds onto the sample point.
    tx_pt    = (hp == DIV_W'(1)) ? '0 : hp - DIV_W'(2);
    active   = !bus.ss && ((bus.spi_mode == MODE_RUN) ||
                           (bus.spi_mode == MODE_WAIT && !bus.spiswai));
    // >= so a divisor shrunk mid-transfer wraps at once instead of overrunning.
    wrap     = (count >= hp_m1);
    cnt_nxt  = wrap ? '0 : count + DIV_W'(1);
    sclk_nxt = wrap ? ~sclk_q : sclk_q;
  end

  // Counter, sclk and strobe registers; strobes are computed from the
  // next state so they line up with the count/sclk they describe.
  always_ff @(posedge PCLK) begin
    if (PRESET || !active) begin
      count        <= '0;
      sclk_q       <= bus.cpol;
      flag_low_q   <= 1'b0;
      flag_high_q  <= 1'b0;
      flags_low_q  <= 1'b0;
      flags_high_q <= 1'b0;
    end else begin
      count        <= cnt_nxt;
      sclk_q       <= sclk_nxt;
      flag_high_q  <=  sclk_nxt && (cnt_nxt == hp_m1);
      flag_low_q   <= !sclk_nxt && (cnt_nxt == hp_m1);
      flags_high_q <=  sclk_nxt && (cnt_nxt == tx_pt);
      flags_low_q  <= !sclk_nxt && (cnt_nxt == tx_pt);
    end
  end

  assign bus.sclk              = sclk_q;
  assign bus.flag_low          = flag_low_q;
  assign bus.flag_high         = flag_high_q;
  assign bus.flags_low         = flags_low_q;
  assign bus.flags_high        = flags_high_q;
  assign bus.baud_rate_divisor = divisor;

endmodule

// File: tb/tb_spi_baud_gen.sv
// Bench for spi_baud_gen: directed scenarios plus random stimulus, checked
// every cycle against an integer model of the half-period clock rules.
module tb_spi_baud_gen;
  import spi_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  spi_baud_gen_if #(.DIV_W(12)) bus();
  spi_baud_gen #(.DIV_W(12)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // Model state: cycles elapsed in the current half period and sclk level.
  int   m_cnt = 0;
  logic m_sclk = 1'b0;
  logic e_fl = 1'b0, e_fh = 1'b0, e_fsl = 1'b0, e_fsh = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int half_period();
    return (int'(bus.sppr) + 1) * (1 << bus.spr);
  endfunction

  function automatic bit is_active();
    return !bus.ss && (bus.spi_mode == 2'b00 || (bus.spi_mode == 2'b01 && !bus.spiswai));
  endfunction

  // One PCLK edge of the reference behaviour.
  task automatic model_edge();
    int hp;
    int shift_pt;
    hp = half_period();
    shift_pt = (hp == 1) ? 0 : hp - 2;
    if (PRESET || !is_active()) begin
      m_cnt = 0; m_sclk = bus.cpol;
      e_fl = 0; e_fh = 0; e_fsl = 0; e_fsh = 0;
    end else begin
      if (m_cnt >= hp - 1) begin
        m_cnt = 0;
        m_sclk = ~m_sclk;
      end else begin
        m_cnt++;
      end
      e_fh  =  m_sclk && (m_cnt == hp - 1);
      e_fl  = !m_sclk && (m_cnt == hp - 1);
      e_fsh =  m_sclk && (m_cnt == shift_pt);
      e_fsl = !m_sclk && (m_cnt == shift_pt);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    model_edge();
    @(negedge PCLK);
    chk("sclk",       bus.sclk,       m_sclk);
    chk("flag_high",  bus.flag_high,  e_fh);
    chk("flag_low",   bus.flag_low,   e_fl);
    chk("flags_high", bus.flags_high, e_fsh);
    chk("flags_low",  bus.flags_low,  e_fsl);
    chk("divisor",    bus.baud_rate_divisor, 32'(2 * half_period()));
  endtask

  // Cycles until sclk changes level (bounded).
  task automatic run_len(output int n);
    logic start;
    start = bus.sclk;
    n = 0;
    while (bus.sclk == start && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    bus.spi_mode = MODE_RUN; bus.spiswai = 0; bus.sppr = 0; bus.spr = 0;
    bus.cpol = 0; bus.cpha = 0; bus.ss = 1; PRESET = 1;
    tick(); tick();
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_flag_high", bus.flag_high, 0);
    PRESET = 0;

    // Fastest clock: toggles every cycle, strobes coincide.
    bus.ss = 0;
    repeat (8) begin
      tick();
      chk("hp1_coincide_hi", bus.flags_high, bus.flag_high);
    end
    chk("hp1_div", bus.baud_rate_divisor, 2);

    // Divisor 12, cpol=1, ss held high then released.
    bus.ss = 1; bus.sppr = 2; bus.spr = 1; bus.cpol = 1;
    repeat (3) tick();
    chk("ss_hold_cpol", bus.sclk, 1);
    chk("div12", bus.baud_rate_divisor, 12);
    bus.ss = 0;
    run_len(n); chk("first_toggle", n, 6);
    run_len(n); chk("low_len", n, 6);
    run_len(n); chk("high_len", n, 6);

    // Wait mode with spiswai freezes, then restarts cleanly.
    repeat (3) tick();
    bus.spi_mode = MODE_WAIT; bus.spiswai = 1;
    repeat (4) tick();
    chk("wait_freeze", bus.sclk, 1);
    chk("wait_flag", bus.flag_high | bus.flag_low | bus.flags_high | bus.flags_low, 0);
    bus.spiswai = 0;
    run_len(n); chk("wait_restart", n, 6);
    bus.spi_mode = MODE_RUN;

    // Divisor shrink mid-half-period: wrap on next edge.
    bus.ss = 1; bus.cpol = 0; bus.sppr = 7; bus.spr = 2;
    tick();
    bus.ss = 0;
    n = 0;
    while (m_cnt != 20 && n < 100) begin tick(); n++; end
    chk("reach_cnt20", (m_cnt == 20), 1);
    chk("pre_shrink_sclk", bus.sclk, 0);
    bus.sppr = 0;
    tick();
    chk("shrink_toggle", bus.sclk, 1);

    // Reset mid-byte while sclk is opposite to cpol.
    bus.sppr = 1; bus.spr = 1;
    n = 0;
    while (bus.sclk != 1 && n < 100) begin tick(); n++; end
    tick();
    PRESET = 1;
    tick();
    chk("rst_mid_sclk", bus.sclk, 0);
    chk("rst_mid_flags", bus.flag_high | bus.flag_low | bus.flags_high | bus.flags_low, 0);
    PRESET = 0;

    // cpol follows within one cycle while inactive.
    bus.ss = 1;
    bus.cpol = 1; tick(); chk("cpol_follow1", bus.sclk, 1);
    bus.cpol = 0; tick(); chk("cpol_follow0", bus.sclk, 0);

    // Random traffic.
    bus.ss = 0;
    repeat (4000) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.sppr = 3'($urandom_range(0, 7));
        bus.spr  = 3'($urandom_range(0, 7) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 2));
      end
      if ($urandom_range(0, 59) == 0) bus.ss = ~bus.ss;
      if ($urandom_range(0, 79) == 0) bus.spi_mode = 2'($urandom_range(0, 7) < 5 ? 0 : $urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.spiswai = ~bus.spiswai;
      if ($urandom_range(0, 99) == 0) bus.cpol = ~bus.cpol;
      bus.cpha = 1'($urandom_range(0, 1));
      PRESET = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
